avst_video_rx_parser: RTL and testbench
=======================================

# avst_video_rx_parser

Avalon-ST video sink that terminates the 3-symbol × 8-bit video stream leaving `filter_2d_ciris`, or any stage using the same packet format. It decodes control packets (width, height, interlace) and checks each video packet against the decoded geometry. Pixels are forwarded on a simple valid/ready pixel port with start-of-frame, end-of-line and end-of-frame markers. It sits at the output of the processing chain, in front of a frame writer or checker.

## Interface
- `BITS_PER_SYMBOL`, 8, bits per colour symbol
- `SYMBOLS_PER_BEAT`, 3, symbols per beat; data width DW = 24
- `clk_i`  in  1  single clock
- `rst_i`  in  1  synchronous reset, active-high
- `avst_din_ready_o`  out  1  sink ready
- `avst_din_valid_i`  in  1  beat valid
- `avst_din_sop_i`  in  1  start of packet
- `avst_din_eop_i`  in  1  end of packet
- `avst_din_data_i`  in  DW  beat data; symbol0 = [7:0]
- `pix_valid_o`  out  1  pixel valid
- `pix_ready_i`  in  1  pixel accepted
- `pix_data_o`  out  DW  pixel
- `pix_sof_o`  out  1  first pixel of frame
- `pix_eol_o`  out  1  last pixel of line
- `pix_eof_o`  out  1  last pixel of frame
- `width_o`, `height_o`  out  16  last accepted geometry
- `interlace_o`  out  4  last accepted interlace nibble
- `ctrl_valid_o`  out  1  one-cycle pulse on geometry update
- `ctrl_err_o`, `short_err_o`, `long_err_o`, `sop_err_o`  out  1  one-cycle error pulses
- `frame_cnt_o`  out  16  completed video frames, wraps

## Operation
- Beat acceptance: a beat transfers when `avst_din_valid_i && avst_din_ready_o`.
- Packet type is `data[3:0]` of the sop beat: 0xF = control, 0x0 = video, anything else = discard.
- **IDLE:** waits for a sop beat. Non-sop beats are dropped silently. The sop beat selects CTRL, VIDEO or DROP.
- **CTRL** collects three beats:
  - b1: sym2 = w[7:4], sym1 = w[11:8], sym0 = w[15:12]
  - b2: sym2 = h[11:8], sym1 = h[15:12], sym0 = w[3:0]
  - b3: sym2 = il[3:0], sym1 = h[3:0], sym0 = h[7:4]
  - Only the low nibble of each symbol is used.
  - Commit on b3 only if b3 has eop, w != 0 and h != 0. Commit updates `width_o`, `height_o`, `interlace_o` and pulses `ctrl_valid_o`.
  - Any other outcome (eop before b3, no eop on b3, zero w or h) pulses `ctrl_err_o` and leaves geometry unchanged.
  - Extra beats after b3 are dropped up to eop.
- **VIDEO:**
  - Every beat after sop is a pixel; the eop beat carries the last pixel.
  - x and y counters (16 bit) start at 0. `eol` = (x == w-1); `eof` = eol && (y == h-1); `sof` = first pixel.
  - Pixel at eof with eop: `frame_cnt_o` increments, return to IDLE.
  - eop before eof: `short_err_o` pulses, the eop pixel is forwarded with `pix_eof_o` = 1, no count increment.
  - Pixels after eof and before eop are dropped; `long_err_o` pulses once per frame.
  - No geometry ever committed since reset: pass the frame through, with eol/eof asserted only on eop.
- **DROP:** accept and discard beats until eop.
- A sop beat in any non-IDLE state pulses `sop_err_o`, aborts the current packet (no eof emitted) and is decoded as a new packet header.
- Geometry is latched at the video sop beat. A control packet arriving mid-frame is impossible because of the sop-abort rule.

## Timing
- Pixel output is a single register stage; latency is 1 cycle from input accept to `pix_valid_o`.
- `avst_din_ready_o` = `!pix_valid_o || pix_ready_i` in VIDEO; 1 in IDLE, CTRL and DROP. It is combinational from `pix_ready_i` and has no dependence on `avst_din_valid_i`.
- `pix_*` outputs stay stable while `pix_valid_o && !pix_ready_i`.
- Error and `ctrl_valid_o` pulses are registered and assert the cycle after the causing beat.
- Reset values:
  - state IDLE
  - all valid/pulse outputs 0
  - `width_o` = `height_o` = 0, `interlace_o` = 0
  - `frame_cnt_o` = 0
  - geometry-valid flag cleared
- Reset mid-frame discards the pending pixel, with no eof.

## Structure
- Package `avst_video_pkg`:
  - packet-type constants (`PKT_VIDEO` = 4'h0, `PKT_CTRL` = 4'hF)
  - state enum `rx_state_t` {IDLE, CTRL, VIDEO, DROP}
  - struct `vid_geom_t` {width, height, interlace}
- Sub-module `avst_ctrl_decode`: combinational nibble unpack of b1..b3 into `vid_geom_t`. It is shared with the future transmitter's packer for symmetry.

## Test plan
- Control packet 20×20, il = 3 → `ctrl_valid_o` pulse; `width_o` = 20, `height_o` = 20, `interlace_o` = 3.
- Then a 400-pixel video packet with `pix_ready_i` = 1 → 20 eol pulses, eof on pixel 400, `frame_cnt_o` = 1, no errors.
- Same frame with `avst_din_valid_i` 90% and `pix_ready_i` random 41% → pixel order and data match the input exactly, eof still on pixel 400.
- 399-pixel packet → `short_err_o`, eof on pixel 399, count unchanged. 405-pixel packet → one `long_err_o`, 400 pixels out.
- Control packet with eop on b2 → `ctrl_err_o`, geometry unchanged. Width 0 → `ctrl_err_o`.
- sop at pixel 150 → `sop_err_o`, new frame starts with `pix_sof_o`. Reset asserted at pixel 200 → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/avst_video_pkg.sv
// Shared types and constants for the Avalon-ST video packet format
// (3 symbols x 8 bits per beat).
package avst_video_pkg;

  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    CTRL,
    VIDEO,
    DROP
  } rx_state_t;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlace;
  } vid_geom_t;

endpackage

// File: rtl/avst_ctrl_decode.sv
// Combinational unpack of the three control-packet payload beats into a geometry
// record. Only the low nibble of each symbol carries information.
module avst_ctrl_decode
  import avst_video_pkg::*;
(
  input  logic [23:0] b1_i,
  input  logic [23:0] b2_i,
  input  logic [23:0] b3_i,
  output vid_geom_t   geom_o
);

  logic unused_hi;

  assign geom_o.width     = {b1_i[3:0], b1_i[11:8], b1_i[19:16], b2_i[3:0]};
  assign geom_o.height    = {b2_i[11:8], b2_i[19:16], b3_i[3:0], b3_i[11:8]};
  assign geom_o.interlace = b3_i[19:16];

  // High nibbles of every symbol are padding in this packet format.
  assign unused_hi = ^{b1_i[23:20], b1_i[15:12], b1_i[7:4],
                       b2_i[23:20], b2_i[15:12], b2_i[7:4],
                       b3_i[23:20], b3_i[15:12], b3_i[7:4]};

endmodule

// File: rtl/avst_video_rx_parser.sv
// Avalon-ST video sink: decodes control packets, checks video packets against the
// decoded geometry and forwards pixels through a single output register stage.
module avst_video_rx_parser
  import avst_video_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3,
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          avst_din_ready_o,
  input  logic          avst_din_valid_i,
  input  logic          avst_din_sop_i,
  input  logic          avst_din_eop_i,
  input  logic [DW-1:0] avst_din_data_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [DW-1:0] pix_data_o,
  output logic          pix_sof_o,
  output logic          pix_eol_o,
  output logic          pix_eof_o,
  output logic [15:0]   width_o,
  output logic [15:0]   height_o,
  output logic [3:0]    interlace_o,
  output logic          ctrl_valid_o,
  output logic          ctrl_err_o,
  output logic          short_err_o,
  output logic          long_err_o,
  output logic          sop_err_o,
  output logic [15:0]   frame_cnt_o
);

  rx_state_t     state_q, state_d;
  logic [1:0]    cbeat_q, cbeat_d;
  logic [DW-1:0] b1_q, b1_d, b2_q, b2_d;
  vid_geom_t     geom_q, geom_d, dec_geom;
  logic          gvld_q, gvld_d;
  logic [15:0]   fw_q, fw_d, fh_q, fh_d, x_q, x_d, y_q, y_d;
  logic          fgv_q, fgv_d, first_q, first_d, past_q, past_d, longed_q, longed_d;
  logic          pvld_q, pvld_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic [DW-1:0] pdata_q, pdata_d;
  logic          cvld_q, cvld_d, cerr_q, cerr_d, short_q, short_d;
  logic          long_q, long_d, soperr_q, soperr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          acc, px_eol, geo_eof;

  avst_ctrl_decode u_dec (
    .b1_i   (b1_q),
    .b2_i   (b2_q),
    .b3_i   (avst_din_data_i),
    .geom_o (dec_geom)
  );

  assign avst_din_ready_o = (state_q == VIDEO) ? (!pvld_q || pix_ready_i) : 1'b1;
  assign acc              = avst_din_valid_i && avst_din_ready_o;
  // Without committed geometry the packet boundary alone marks line and frame end.
  assign px_eol  = fgv_q ? (x_q == fw_q - 16'd1) : avst_din_eop_i;
  assign geo_eof = fgv_q ? (px_eol && (y_q == fh_q - 16'd1)) : avst_din_eop_i;

  always_comb begin
    state_d  = state_q;
    cbeat_d  = cbeat_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    geom_d   = geom_q;
    gvld_d   = gvld_q;
    fw_d     = fw_q;
    fh_d     = fh_q;
    fgv_d    = fgv_q;
    x_d      = x_q;
    y_d      = y_q;
    first_d  = first_q;
    past_d   = past_q;
    longed_d = longed_q;
    pvld_d   = pvld_q && !pix_ready_i;
    pdata_d  = pdata_q;
    sof_d    = sof_q;
    eol_d    = eol_q;
    eof_d    = eof_q;
    cvld_d   = 1'b0;
    cerr_d   = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    soperr_d = 1'b0;
    cnt_d    = cnt_q;
    if (acc) begin
      if (avst_din_sop_i) begin
        soperr_d = (state_q != IDLE);
        cbeat_d  = 2'd0;
        x_d      = 16'd0;
        y_d      = 16'd0;
        first_d  = 1'b1;
        past_d   = 1'b0;
        longed_d = 1'b0;
        fw_d     = geom_q.width;
        fh_d     = geom_q.height;
        fgv_d    = gvld_q;
        case (avst_din_data_i[3:0])
          PKT_CTRL:  state_d = CTRL;
          PKT_VIDEO: state_d = VIDEO;
          default:   state_d = DROP;
        endcase
      end else begin
        case (state_q)
          CTRL: begin
            if (cbeat_q == 2'd0) b1_d = avst_din_data_i;
            if (cbeat_q == 2'd1) b2_d = avst_din_data_i;
            if (cbeat_q == 2'd2) begin
              if (avst_din_eop_i && dec_geom.width != 16'd0 && dec_geom.height != 16'd0) begin
                geom_d = dec_geom;
                gvld_d = 1'b1;
                cvld_d = 1'b1;
              end else begin
                cerr_d = 1'b1;
              end
              state_d = avst_din_eop_i ? IDLE : DROP;
            end else if (avst_din_eop_i) begin
              cerr_d  = 1'b1;
              state_d = IDLE;
            end
            cbeat_d = cbeat_q + 2'd1;
          end
          VIDEO: begin
            if (past_q) begin
              if (!longed_q) begin
                long_d   = 1'b1;
                longed_d = 1'b1;
              end
              if (avst_din_eop_i) state_d = IDLE;
            end else begin
              pvld_d  = 1'b1;
              pdata_d = avst_din_data_i;
              sof_d   = first_q;
              eol_d   = px_eol;
              eof_d   = geo_eof || avst_din_eop_i;
              first_d = 1'b0;
              if (px_eol) begin
                x_d = 16'd0;
                y_d = y_q + 16'd1;
              end else begin
                x_d = x_q + 16'd1;
              end
              if (avst_din_eop_i) begin
                state_d = IDLE;
                if (geo_eof) cnt_d = cnt_q + 16'd1;
                else         short_d = 1'b1;
              end else if (geo_eof) begin
                past_d = 1'b1;
              end
            end
          end
          DROP: if (avst_din_eop_i) state_d = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cbeat_q  <= 2'd0;
      geom_q   <= '0;
      gvld_q   <= 1'b0;
      fgv_q    <= 1'b0;
      x_q      <= 16'd0;
      y_q      <= 16'd0;
      first_q  <= 1'b0;
      past_q   <= 1'b0;
      longed_q <= 1'b0;
      pvld_q   <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      cvld_q   <= 1'b0;
      cerr_q   <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      soperr_q <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      cbeat_q  <= cbeat_d;
      geom_q   <= geom_d;
      gvld_q   <= gvld_d;
      fgv_q    <= fgv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      first_q  <= first_d;
      past_q   <= past_d;
      longed_q <= longed_d;
      pvld_q   <= pvld_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      cvld_q   <= cvld_d;
      cerr_q   <= cerr_d;
      short_q  <= short_d;
      long_q   <= long_d;
      soperr_q <= soperr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    b1_q    <= b1_d;
    b2_q    <= b2_d;
    fw_q    <= fw_d;
    fh_q    <= fh_d;
    pdata_q <= pdata_d;
  end

  assign pix_valid_o  = pvld_q;
  assign pix_data_o   = pdata_q;
  assign pix_sof_o    = sof_q;
  assign pix_eol_o    = eol_q;
  assign pix_eof_o    = eof_q;
  assign width_o      = geom_q.width;
  assign height_o     = geom_q.height;
  assign interlace_o  = geom_q.interlace;
  assign ctrl_valid_o = cvld_q;
  assign ctrl_err_o   = cerr_q;
  assign short_err_o  = short_q;
  assign long_err_o   = long_q;
  assign sop_err_o    = soperr_q;
  assign frame_cnt_o  = cnt_q;

endmodule

// File: tb/tb_avst_video_rx_parser.sv
// Directed bench for avst_video_rx_parser with a packet-level expected-pixel model.
module tb_avst_video_rx_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [23:0] din_data = '0;
  logic        pix_ready = 1'b1;
  logic        din_ready, pix_valid_o, pix_sof_o, pix_eol_o, pix_eof_o;
  logic [23:0] pix_data_o;
  logic [15:0] width_o, height_o, frame_cnt_o;
  logic [3:0]  interlace_o;
  logic        ctrl_valid_o, ctrl_err_o, short_err_o, long_err_o, sop_err_o;

  avst_video_rx_parser dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .avst_din_ready_o (din_ready),
    .avst_din_valid_i (din_valid),
    .avst_din_sop_i   (din_sop),
    .avst_din_eop_i   (din_eop),
    .avst_din_data_i  (din_data),
    .pix_valid_o      (pix_valid_o),
    .pix_ready_i      (pix_ready),
    .pix_data_o       (pix_data_o),
    .pix_sof_o        (pix_sof_o),
    .pix_eol_o        (pix_eol_o),
    .pix_eof_o        (pix_eof_o),
    .width_o          (width_o),
    .height_o         (height_o),
    .interlace_o      (interlace_o),
    .ctrl_valid_o     (ctrl_valid_o),
    .ctrl_err_o       (ctrl_err_o),
    .short_err_o      (short_err_o),
    .long_err_o       (long_err_o),
    .sop_err_o        (sop_err_o),
    .frame_cnt_o      (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
    logic        eof;
  } px_t;

  int   checks = 0, errors = 0;
  px_t  exp_q[$];
  bit   mon_en = 1'b1;
  int   rdy_pct = 100, vld_pct = 100;
  logic [15:0] m_w = '0, m_h = '0;
  logic [3:0]  m_il = '0;
  bit   m_gv = 1'b0;
  int   m_cnt = 0;
  int   n_ctrl = 0, n_cerr = 0, n_short = 0, n_long = 0, n_soperr = 0;
  int   e_ctrl = 0, e_cerr = 0, e_short = 0, e_long = 0, e_soperr = 0;
  int   n_pix = 0, n_eol = 0, n_eof = 0;
  px_t  prev;
  bit   stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    pix_ready = (rdy_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < rdy_pct);
  end

  // Per-cycle compare of the pixel port and pulse tally.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall)
        chk("pix_hold", {pix_valid_o, pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o}, {1'b1, prev});
      stall = pix_valid_o && !pix_ready;
      prev  = {pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o};
      if (pix_valid_o && pix_ready) begin
        n_pix++;
        n_eol += int'(pix_eol_o);
        n_eof += int'(pix_eof_o);
        if (exp_q.size() == 0) chk("extra_pixel", {pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o}, 64'hDEAD);
        else chk("pixel", {pix_data_o, pix_sof_o, pix_eol_o, pix_eof_o}, exp_q.pop_front());
      end
      n_ctrl   += int'(ctrl_valid_o);
      n_cerr   += int'(ctrl_err_o);
      n_short  += int'(short_err_o);
      n_long   += int'(long_err_o);
      n_soperr += int'(sop_err_o);
    end else begin
      stall = 1'b0;
    end
  end

  task automatic send(input logic [23:0] d, input logic s, input logic e);
    int guard = 0;
    bit took = 1'b0;
    while (vld_pct < 100 && int'($urandom_range(99)) >= vld_pct) begin
      din_valid = 1'b0;
      @(posedge clk); #1;
    end
    din_valid = 1'b1; din_data = d; din_sop = s; din_eop = e;
    while (!took && guard < 1000) begin
      @(negedge clk);
      took = din_ready;
      @(posedge clk); #1;
      guard++;
    end
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    if (!took) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_ctrl_valid_cnt"}, n_ctrl, e_ctrl);
    chk({tag, "_ctrl_err_cnt"}, n_cerr, e_cerr);
    chk({tag, "_short_cnt"}, n_short, e_short);
    chk({tag, "_long_cnt"}, n_long, e_long);
    chk({tag, "_sop_err_cnt"}, n_soperr, e_soperr);
    chk({tag, "_frame_cnt"}, frame_cnt_o, m_cnt);
  endtask

  task automatic ctrl_pkt(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                          input int nb);
    logic [23:0] b [3];
    bit commit;
    b[0] = {4'hA, w[7:4],   4'h5, w[11:8],  4'h3, w[15:12]};
    b[1] = {4'hA, h[11:8],  4'h5, h[15:12], 4'h3, w[3:0]};
    b[2] = {4'hA, il,       4'h5, h[3:0],   4'h3, h[7:4]};
    commit = (nb == 3) && (w != 0) && (h != 0);
    send(24'hC3C3CF, 1'b1, 1'b0);
    chk("ctrl_hdr_sop_err", sop_err_o, 0);
    for (int k = 0; k < nb; k++) send(b[k], 1'b0, k == nb - 1);
    chk("ctrl_valid_pulse", ctrl_valid_o, commit);
    chk("ctrl_err_pulse", ctrl_err_o, !commit);
    if (commit) begin
      m_w = w; m_h = h; m_il = il; m_gv = 1'b1; e_ctrl++;
    end else begin
      e_cerr++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("width", width_o, m_w);
    chk("height", height_o, m_h);
    chk("interlace", interlace_o, m_il);
  endtask

  // Sends a video packet of n pixels; abort leaves it without eop.
  task automatic video_pkt(input int n, input bit abort, input bit hdr_soperr);
    int total, mw;
    logic [23:0] d;
    bit last;
    mw    = int'(m_w);
    total = int'(m_w) * int'(m_h);
    send(24'h5A5A50, 1'b1, 1'b0);
    chk("vid_hdr_sop_err", sop_err_o, hdr_soperr);
    if (hdr_soperr) e_soperr++;
    for (int i = 0; i < n; i++) begin
      d    = 24'($urandom);
      last = !abort && (i == n - 1);
      if (m_gv) begin
        if (i < total) exp_q.push_back({d, i == 0, (i % mw) == mw - 1, (i == total - 1) || last});
      end else begin
        exp_q.push_back({d, i == 0, last, last});
      end
      send(d, 1'b0, last);
      if (last && m_gv && n < total) chk("short_pulse", short_err_o, 1);
    end
    if (!abort) begin
      if (!m_gv || n == total) m_cnt++;
      else if (n < total) e_short++;
    end
    if (m_gv && n > total) e_long++;
  endtask

  int p0, l0, f0;

  task automatic snap();
    p0 = n_pix; l0 = n_eol; f0 = n_eof;
  endtask

  task automatic deltas(input string tag, input int p, input int l, input int f);
    chk({tag, "_pixels"}, n_pix - p0, p);
    chk({tag, "_eols"}, n_eol - l0, l);
    chk({tag, "_eofs"}, n_eof - f0, f);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_ctrl_valid", ctrl_valid_o, 0);
    chk("rst_errs", {ctrl_err_o, short_err_o, long_err_o, sop_err_o}, 0);
    chk("rst_geom", {width_o, height_o, interlace_o}, 0);
    chk("rst_frame_cnt", frame_cnt_o, 0);
    chk("rst_din_ready", din_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    ctrl_pkt(16'd20, 16'd20, 4'd3, 3);
    chk("lit_width20", width_o, 16'd20);
    chk("lit_height20", height_o, 16'd20);
    chk("lit_il3", interlace_o, 4'd3);

    snap(); video_pkt(400, 1'b0, 1'b0); drain();
    deltas("frame400", 400, 20, 1);
    chk("lit_frame_cnt1", frame_cnt_o, 16'd1);
    check_counts("frame400");

    vld_pct = 90; rdy_pct = 41;
    snap(); video_pkt(400, 1'b0, 1'b0); drain();
    vld_pct = 100; rdy_pct = 100;
    deltas("frame400_bp", 400, 20, 1);
    chk("lit_frame_cnt2", frame_cnt_o, 16'd2);
    check_counts("frame400_bp");

    snap(); video_pkt(399, 1'b0, 1'b0); drain();
    deltas("short399", 399, 19, 1);
    check_counts("short399");

    snap(); video_pkt(405, 1'b0, 1'b0); drain();
    deltas("long405", 400, 20, 1);
    chk("lit_long_cnt", n_long, 1);
    check_counts("long405");

    ctrl_pkt(16'd7, 16'd9, 4'd1, 2);
    ctrl_pkt(16'd0, 16'd20, 4'd3, 3);
    chk("lit_width_kept", width_o, 16'd20);
    check_counts("ctrl_errs");

    snap();
    video_pkt(149, 1'b1, 1'b0);
    video_pkt(400, 1'b0, 1'b1);
    drain();
    deltas("sop_abort", 549, 27, 1);
    chk("lit_frame_cnt3", frame_cnt_o, 16'd3);
    check_counts("sop_abort");

    mon_en = 1'b0;
    video_pkt(200, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_pix_valid", pix_valid_o, 0);
    chk("midrst_pulses", {ctrl_valid_o, ctrl_err_o, short_err_o, long_err_o, sop_err_o}, 0);
    chk("midrst_geom", {width_o, height_o, interlace_o}, 0);
    chk("midrst_frame_cnt", frame_cnt_o, 0);
    rst = 1'b0;
    exp_q.delete();
    m_w = '0; m_h = '0; m_il = '0; m_gv = 1'b0; m_cnt = 0;
    n_ctrl = 0; n_cerr = 0; n_short = 0; n_long = 0; n_soperr = 0;
    e_ctrl = 0; e_cerr = 0; e_short = 0; e_long = 0; e_soperr = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    snap(); video_pkt(5, 1'b0, 1'b0); drain();
    deltas("passthru", 5, 1, 1);
    check_counts("passthru");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
